// File: rtl/jk_flip_flop.sv
// Vector of independent edge-triggered JK flip-flops with asynchronous active-high reset.
// Define JK_QN_EN to add the complemented output qn.
module jk_flip_flop #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             res,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
`ifdef JK_QN_EN
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
`else
   output logic [WIDTH-1:0] q
`endif
);

   // Each bit: J sets or toggles a cleared bit, a set bit survives unless K clears it.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         q <= RESET_VALUE;
      end else begin
         q <= (J & ~q) | (~K & q);
      end
   end

`ifdef JK_QN_EN
   assign qn = ~q;
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop: a single-bit instance and a 4-bit instance with a nonzero
// reset value, driven by directed steps and random J/K commands against a per-bit command model.
module tb_jk_flip_flop;

   localparam logic [3:0] RESET4 = 4'b1010;

   logic       clk;
   logic       res;
   logic       j1, k1;
   logic [3:0] j4, k4;
   logic       q1;
   logic [3:0] q4;
`ifdef JK_QN_EN
   logic       qn1;
   logic [3:0] qn4;
`endif

   logic       exp1;
   logic [3:0] exp4;
   int         compared;
   int         mismatched;

   jk_flip_flop dutBit (
      .clk (clk),
      .res (res),
      .J   (j1),
      .K   (k1),
`ifdef JK_QN_EN
      .q   (q1),
      .qn  (qn1)
`else
      .q   (q1)
`endif
   );

   jk_flip_flop #(.WIDTH(4), .RESET_VALUE(RESET4)) dutVec (
      .clk (clk),
      .res (res),
      .J   (j4),
      .K   (k4),
`ifdef JK_QN_EN
      .q   (q4),
      .qn  (qn4)
`else
      .q   (q4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decode each bit's J/K pair as a hold/clear/set/toggle command.
   function automatic logic [3:0] modelNext(input logic [3:0] cur, input logic [3:0] j,
                                            input logic [3:0] k);
      logic [3:0] nxt;
      nxt = cur;
      for (int i = 0; i < 4; i++) begin
         case ({j[i], k[i]})
            2'b00:   nxt[i] = cur[i];
            2'b01:   nxt[i] = 1'b0;
            2'b10:   nxt[i] = 1'b1;
            default: nxt[i] = ~cur[i];
         endcase
      end
      return nxt;
   endfunction

   task automatic checkOutput(input string tag);
      compared++;
      assert (q1 === exp1) else begin
         mismatched++;
         $error("[TB] FAIL %s q1: observed %b expected %b", tag, q1, exp1);
      end
      compared++;
      assert (q4 === exp4) else begin
         mismatched++;
         $error("[TB] FAIL %s q4: observed %b expected %b", tag, q4, exp4);
      end
`ifdef JK_QN_EN
      compared++;
      assert (qn1 === ~exp1) else begin
         mismatched++;
         $error("[TB] FAIL %s qn1: observed %b expected %b", tag, qn1, ~exp1);
      end
      compared++;
      assert (qn4 === ~exp4) else begin
         mismatched++;
         $error("[TB] FAIL %s qn4: observed %b expected %b", tag, qn4, ~exp4);
      end
`endif
   endtask

   // Drive one command set, let a rising edge take it, and advance the model to match.
   task automatic applyStimulus(input logic nj1, input logic nk1, input logic [3:0] nj4,
                                input logic [3:0] nk4, input logic nres);
      logic [3:0] cur1;
      j1  = nj1;
      k1  = nk1;
      j4  = nj4;
      k4  = nk4;
      res = nres;
      if (nres) begin
         exp1 = 1'b0;
         exp4 = RESET4;
      end
      @(posedge clk);
      if (!nres) begin
         cur1 = {3'b000, exp1};
         cur1 = modelNext(cur1, {3'b000, nj1}, {3'b000, nk1});
         exp1 = cur1[0];
         exp4 = modelNext(exp4, nj4, nk4);
      end
      #1;
   endtask

   task automatic pulseResetMidCycle(input string tag);
      #2 res = 1'b1;
      exp1 = 1'b0;
      exp4 = RESET4;
      #1 checkOutput(tag);
      res = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      res  = 1'b1;
      j1   = 1'b0;
      k1   = 1'b0;
      j4   = 4'b0000;
      k4   = 4'b0000;
      exp1 = 1'b0;
      exp4 = RESET4;

      #1 checkOutput("resetImmediate");
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
      checkOutput("resetHeld");
      applyStimulus(1'b0, 1'b1, 4'h0, 4'hF, 1'b1);
      checkOutput("resetWithClear");
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
      checkOutput("resetBeatsToggle");

      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      checkOutput("holdZero");

      j1 = 1'b1;
      k1 = 1'b0;
      #1 checkOutput("setNotBeforeEdge");
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      checkOutput("setAfterEdge");
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      checkOutput("holdOne");
      applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
      checkOutput("clearCommand");
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      checkOutput("setAgain");

      j1 = 1'b1;
      k1 = 1'b1;
      j4 = 4'hF;
      k4 = 4'hF;
      pulseResetMidCycle("asyncResetMidCycle");
      res = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
      checkOutput("toggleUnderResetA");
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
      checkOutput("toggleUnderResetB");
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
      checkOutput("toggleRelease1");
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
      checkOutput("toggleRelease2");
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
      checkOutput("toggleRelease3");

      applyStimulus(1'b0, 1'b0, 4'b0101, 4'b1010, 1'b0);
      checkOutput("vectorLoad");
      applyStimulus(1'b0, 1'b0, 4'b1100, 4'b1010, 1'b0);
      checkOutput("vectorMixed");

      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'b0);
         checkOutput("random");
         if ($urandom_range(0, 15) == 0) begin
            pulseResetMidCycle("randomAsyncReset");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
